// File: rtl/snn_pkg.sv
// Shared constants for the SNN readout path: neuron geometry, window timing and
// the vote decoder FSM encoding.
package snn_pkg;

  localparam int N_NEURON    = 10;
  localparam int PRESENT_CYC = 336;
  localparam int WIN_LEN     = 2 * PRESENT_CYC;
  localparam int CNT_W       = 10;
  localparam int ID_W        = 4;
  localparam int NO_CLASS    = N_NEURON;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/spike_vote_decoder_cnt.sv
// One per-neuron spike counter: synchronous clear, increment that sticks at all-ones.
module spike_cnt_sat #(
  parameter int W = snn_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over increment so a new window always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spike_vote_decoder.sv
// Readout stage: counts output spikes per neuron over one window, then picks the
// neuron with the most spikes (lowest index on ties) and strobes the class result.
module spike_vote_decoder #(
  parameter int N_NEURON = snn_pkg::N_NEURON,
  parameter int WIN_LEN  = snn_pkg::WIN_LEN,
  parameter int CNT_W    = snn_pkg::CNT_W,
  parameter int ID_W     = snn_pkg::ID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                win_start,
  input  logic                learn,
  input  logic [N_NEURON-1:0] spike,
  output logic                class_valid,
  output logic [ID_W-1:0]     class_id,
  output logic [CNT_W-1:0]    max_count,
  output logic                is_train,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  import snn_pkg::*;

  localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int IX_W = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(N_NEURON - 1);

  // Interface: win_start is a one-cycle pulse with no ready; class_valid is a one-cycle
  // strobe with no backpressure, and the result fields hold until the next strobe.
  logic [1:0]       r_state;
  logic [WC_W-1:0]  r_win_cnt;
  logic [IX_W-1:0]  r_scan_idx;
  logic [IX_W-1:0]  r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic             r_learn;
  logic             r_valid;
  logic [ID_W-1:0]  r_class_id;
  logic [CNT_W-1:0] r_max_count;
  logic             r_is_train;

  logic             w_count_en;
  logic [CNT_W-1:0] w_cnt [N_NEURON];
  logic [CNT_W-1:0] w_scan_cnt;

  // A win_start edge clears the counters, so it must not also count that cycle's spikes.
  assign w_count_en = (r_state == ST_COUNT) && !win_start;

  for (genvar g = 0; g < N_NEURON; g++) begin : g_cnt
    spike_cnt_sat #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (win_start),
      .i_inc (w_count_en & spike[g]),
      .o_cnt (w_cnt[g])
    );
  end

  assign w_scan_cnt = w_cnt[r_scan_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_win_cnt   <= '0;
      r_scan_idx  <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_learn     <= 1'b0;
      r_valid     <= 1'b0;
      r_class_id  <= '0;
      r_max_count <= '0;
      r_is_train  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_COUNT: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          if (r_win_cnt == WC_LAST) begin
            r_state    <= ST_SCAN;
            r_scan_idx <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
          end
        end
        ST_SCAN: begin
          // Strictly greater keeps the earliest index on ties.
          if (w_scan_cnt > r_best_cnt) begin
            r_best_cnt <= w_scan_cnt;
            r_best_idx <= r_scan_idx;
          end
          r_scan_idx <= r_scan_idx + 1'b1;
          if (r_scan_idx == IX_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_valid     <= 1'b1;
          r_class_id  <= (r_best_cnt == '0) ? ID_W'(N_NEURON) : ID_W'(r_best_idx);
          r_max_count <= r_best_cnt;
          r_is_train  <= r_learn;
          r_state     <= ST_IDLE;
        end
        default: ;
      endcase
      // A new window overrides the state step above; a pending DONE result still emits.
      if (win_start) begin
        r_state   <= ST_COUNT;
        r_win_cnt <= '0;
        r_learn   <= learn;
      end
    end
  end

  assign class_valid = r_valid;
  assign class_id    = r_class_id;
  assign max_count   = r_max_count;
  assign is_train    = r_is_train;
  assign busy        = (r_state == ST_COUNT) || (r_state == ST_SCAN);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spike_vote_decoder.sv
// Bench for spike_vote_decoder: a default instance and a CNT_W=6 instance share stimulus;
// every window's expected result is queued and checked when the strobe arrives.
module tb_spike_vote_decoder;

  localparam int N      = 10;
  localparam int WIN    = 672;
  localparam int LAT    = 683;
  localparam int SATMAX = 63;
  localparam int EW     = 57;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         win_start = 1'b0;
  logic         learn = 1'b0;
  logic [N-1:0] spike = '0;

  logic         cv, tr, bsy;
  logic [3:0]   cid;
  logic [9:0]   mx;
  logic [1:0]   dbg;
  logic         s_cv, s_tr, s_bsy;
  logic [3:0]   s_cid;
  logic [5:0]   s_mx;
  logic [1:0]   s_dbg;

  always #5 clk = ~clk;

  spike_vote_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .win_start(win_start), .learn(learn), .spike(spike),
    .class_valid(cv), .class_id(cid), .max_count(mx), .is_train(tr), .busy(bsy),
    .dbg_state(dbg)
  );

  spike_vote_decoder #(.CNT_W(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .win_start(win_start), .learn(learn), .spike(spike),
    .class_valid(s_cv), .class_id(s_cid), .max_count(s_mx), .is_train(s_tr), .busy(s_bsy),
    .dbg_state(s_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  // {due cycle[32], id[4], max[10], sat id[4], sat max[6], train[1]}
  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  stim [WIN];
  int last_id = 0, last_mx = 0, last_tr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (cyc > int'(e[56:25])) begin
        total++;
        bad++;
        $display("FAIL strobe_missing: none at cycle %0d, now %0d", e[56:25], cyc);
        void'(exp_q.pop_front());
      end
    end
    if (cv) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: class_valid=1 at cycle %0d expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("latency",       32'(cyc),   32'(e[56:25]));
        chk("class_id",      32'(cid),   32'(e[24:21]));
        chk("max_count",     32'(mx),    32'(e[20:11]));
        chk("is_train",      32'(tr),    32'(e[0]));
        chk("sat_valid",     32'(s_cv),  1);
        chk("sat_class_id",  32'(s_cid), 32'(e[10:7]));
        chk("sat_max_count", 32'(s_mx),  32'(e[6:1]));
        chk("sat_is_train",  32'(s_tr),  32'(e[0]));
        last_id = int'(e[24:21]);
        last_mx = int'(e[20:11]);
        last_tr = int'(e[0]);
      end
    end else if (s_cv) begin
      total++;
      bad++;
      $display("FAIL sat_unexpected_strobe: sat class_valid=1 at cycle %0d expected 0", cyc);
    end
  end

  // ---------------- reference model ----------------
  // Votes are simply the number of set bits per lane, clipped at the counter ceiling;
  // the first lane holding the largest nonzero vote wins.
  task automatic model(input int cap, output int id, output int best);
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < WIN; c++)
      for (int i = 0; i < N; i++)
        if (stim[c][i]) cnt[i]++;
    id = N;
    best = 0;
    for (int i = 0; i < N; i++) begin
      int v;
      v = (cnt[i] > cap) ? cap : cnt[i];
      if (v > best) begin
        best = v;
        id = i;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      win_start = 1'b0;
      spike = (k == 0) ? '1 : N'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic fill_random(input int maxd);
    int d [N];
    for (int i = 0; i < N; i++) d[i] = $urandom_range(0, maxd);
    for (int c = 0; c < WIN; c++)
      for (int i = 0; i < N; i++)
        stim[c][i] = ($urandom_range(0, 999) < d[i]);
  endtask

  task automatic fill_lanes(input int la, input int na, input int lb, input int nb);
    for (int c = 0; c < WIN; c++) begin
      stim[c] = '0;
      if (la >= 0 && c < na) stim[c][la] = 1'b1;
      if (lb >= 0 && c < nb) stim[c][lb] = 1'b1;
    end
  endtask

  // Pulse win_start (with all spikes high on that cycle), play stim[] over the window
  // while toggling learn randomly, and queue the result unless aborted early.
  task automatic run_window(input bit lrn, input int abort_at, input bit given,
                            input int gid, input int gmx, input int gsid, input int gmxs);
    int id, bmx, sid, smx, e0;
    if (given) begin
      id = gid; bmx = gmx; sid = gsid; smx = gmxs;
    end else begin
      model(1 << 30, id, bmx);
      model(SATMAX, sid, smx);
    end
    win_start = 1'b1;
    learn = lrn;
    spike = '1;
    @(negedge clk);
    e0 = cyc;
    win_start = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      if (abort_at > 0 && c == abort_at) return;
      spike = stim[c];
      learn = 1'($urandom);
      @(negedge clk);
      if (c == 5) begin
        chk("busy_count", 32'(bsy), 1);
        chk("sat_busy_count", 32'(s_bsy), 1);
      end
    end
    exp_q.push_back({32'(e0 + LAT), 4'(id), 10'(bmx), 4'(sid), 6'(smx), lrn});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int la; int na; int lb; int nb; bit lrn;
    int exp_id; int exp_mx; int exp_sid; int exp_smx;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{3, 100, 7, 40,  1'b0, 3,  100, 3,  63};
    vecs[1] = '{2, 50,  5, 50,  1'b0, 2,  50,  2,  50};
    vecs[2] = '{-1, 0, -1, 0,   1'b0, 10, 0,   10, 0};
    vecs[3] = '{9, 672, -1, 0,  1'b1, 9,  672, 9,  63};
    vecs[4] = '{8, 70,  1, 64,  1'b1, 8,  70,  1,  63};

    // reset, with all spike lanes high
    rst_n = 1'b0;
    spike = '1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(cv), 0);
    chk("rst_class_id", 32'(cid), 0);
    chk("rst_max_count", 32'(mx), 0);
    chk("rst_is_train", 32'(tr), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_state", 32'(dbg), 0);
    chk("rst_sat_max", 32'(s_mx), 0);
    chk("rst_sat_state", 32'(s_dbg), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_valid", 32'(cv), 0);
    chk("idle_busy", 32'(bsy), 0);
    chk("idle_state", 32'(dbg), 0);
    chk("idle_max_count", 32'(mx), 0);

    for (int v = 0; v < 5; v++) begin
      fill_lanes(vecs[v].la, vecs[v].na, vecs[v].lb, vecs[v].nb);
      run_window(vecs[v].lrn, 0, 1'b1, vecs[v].exp_id, vecs[v].exp_mx,
                 vecs[v].exp_sid, vecs[v].exp_smx);
      idle(15);
      chk("done_busy", 32'(bsy), 0);
    end

    // window edges: samples at E1 and E_WIN_LEN count, E0 and E_WIN_LEN+1 do not
    fill_lanes(-1, 0, -1, 0);
    stim[0][4] = 1'b1;
    stim[WIN-1][4] = 1'b1;
    run_window(1'b0, 0, 1'b1, 4, 2, 4, 2);
    idle(15);

    // restart 300 cycles into COUNT: only the second window reports
    fill_random(150);
    run_window(1'b1, 300, 1'b0, 0, 0, 0, 0);
    fill_random(150);
    run_window(1'b0, 0, 1'b0, 0, 0, 0, 0);
    idle(15);

    // win_start landing on DONE: first result still emits, second window follows
    fill_random(100);
    run_window(1'b1, 0, 1'b0, 0, 0, 0, 0);
    idle(10);
    fill_random(100);
    run_window(1'b0, 0, 1'b0, 0, 0, 0, 0);
    idle(15);

    // reset mid-window: no result, outputs back to zero
    fill_random(150);
    run_window(1'b1, 100, 1'b0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bsy), 0);
    chk("midrst_class_id", 32'(cid), 0);
    chk("midrst_max_count", 32'(mx), 0);
    chk("midrst_is_train", 32'(tr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_id = 0; last_mx = 0; last_tr = 0;
    idle(30);

    // randomized windows, dense (saturating) and sparse (tie-prone)
    for (int r = 0; r < 6; r++) begin
      fill_random((r % 2 == 0) ? 150 : 3);
      run_window(1'($urandom), 0, 1'b0, 0, 0, 0, 0);
      idle($urandom_range(12, 30));
    end

    for (int k = 0; k < 800; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    idle(20);
    chk("hold_class_id", 32'(cid), 32'(last_id));
    chk("hold_max_count", 32'(mx), 32'(last_mx));
    chk("hold_is_train", 32'(tr), 32'(last_tr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
